// File: rtl/hazard_pkg.sv
// Shared encodings for the ID-stage hazard scoreboard: stall-cause codes and
// the default result latencies that the decoder drives onto dst_lat.
package hazard_pkg;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_RAW  = 2'b01;
  localparam logic [1:0] CAUSE_MD   = 2'b10;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

endpackage

// File: rtl/md_busy_timer.sv
// HI/LO busy timer: loads the mult or div latency when one issues and counts
// down to zero. The multiply/divide unit cannot be cancelled, so there is no flush input.
module md_busy_timer #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  // The counter is sized from the latencies because DIV_LAT can exceed the scoreboard width.
  parameter int MW = $clog2(((MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT) + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  logic [MW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= is_div ? MW'(DIV_LAT) : MW'(MULT_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - MW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall controller beside the ID stage: per-register countdown scoreboard for
// RAW hazards plus a HI/LO busy timer, with a cause code and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int NSRC     = 2,
  parameter int CW       = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int AW       = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [NSRC*AW-1:0]  src_reg,
  input  logic [NSRC-1:0]     src_used,
  input  logic [NSRC-1:0]     src_early,
  input  logic                dst_we,
  input  logic [AW-1:0]       dst_reg,
  input  logic [CW-1:0]       dst_lat,
  input  logic                md_start,
  input  logic                md_is_div,
  input  logic                md_use,
  input  logic                flush,
  output logic                stall,
  output logic [1:0]          stall_cause,
  output logic [15:0]         stall_count
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [CW-1:0] score [NREG];
  logic          raw_hit;
  logic          md_busy;
  logic          md_hit;
  logic          accept;

  // Early operands are read in ID, so any pending count blocks them; EX operands
  // can take a result that becomes forwardable this cycle (count of 1).
  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_used[i] && (src_reg[i*AW +: AW] != '0)) begin
        if (src_early[i]) begin
          if (score[src_reg[i*AW +: AW]] != '0) raw_hit = 1'b1;
        end else begin
          if (score[src_reg[i*AW +: AW]] > CW'(1)) raw_hit = 1'b1;
        end
      end
    end
  end

  assign md_hit      = md_use & md_busy;
  assign stall       = issue_valid & ~flush & (raw_hit | md_hit);
  assign stall_cause = !stall ? CAUSE_NONE : (raw_hit ? CAUSE_RAW : CAUSE_MD);
  assign accept      = issue_valid & ~stall & ~flush;

  // Entry 0 is held at zero so r0 never produces a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) score[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0 || flush) begin
          score[r] <= '0;
        end else if (accept && dst_we && (dst_reg == AW'(r))) begin
          score[r] <= dst_lat;
        end else if (score[r] != '0) begin
          score[r] <= score[r] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall) begin
      stall_count <= sat_inc(stall_count);
    end
  end

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept & md_start),
    .is_div (md_is_div),
    .busy   (md_busy)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed cycle table, hand sequences for flush and
// async reset, randomized traffic against a ready-time model, and counter saturation.
module tb_hazard_scoreboard;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CW   = 3;
  localparam int MLAT = 5;
  localparam int DLAT = 10;

  typedef struct {
    logic       iv;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] used;
    logic [1:0] early;
    logic       we;
    logic [4:0] dreg;
    logic [2:0] lat;
    logic       mds;
    logic       mdd;
    logic       mdu;
    logic       fl;
    logic       es;
    logic [1:0] ec;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [9:0]  src_reg;
  logic [1:0]  src_used;
  logic [1:0]  src_early;
  logic        dst_we;
  logic [4:0]  dst_reg;
  logic [2:0]  dst_lat;
  logic        md_start;
  logic        md_is_div;
  logic        md_use;
  logic        flush;
  logic        stall;
  logic [1:0]  stall_cause;
  logic [15:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: absolute cycle at which each register is usable.
  longint now;
  longint rdy_ex [NREG];
  longint rdy_id [NREG];
  longint md_rdy;
  int     m_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREG(NREG), .NSRC(2), .CW(CW), .MULT_LAT(MLAT), .DIV_LAT(DLAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .src_reg(src_reg),
    .src_used(src_used), .src_early(src_early), .dst_we(dst_we), .dst_reg(dst_reg),
    .dst_lat(dst_lat), .md_start(md_start), .md_is_div(md_is_div), .md_use(md_use),
    .flush(flush), .stall(stall), .stall_cause(stall_cause), .stall_count(stall_count)
  );

  function automatic vec_t mk(logic iv, logic [4:0] s0, logic [4:0] s1, logic [1:0] used,
                              logic [1:0] early, logic we, logic [4:0] dreg, logic [2:0] lat,
                              logic mds, logic mdd, logic mdu, logic fl, logic es, logic [1:0] ec);
    vec_t v;
    v.iv = iv; v.s0 = s0; v.s1 = s1; v.used = used; v.early = early;
    v.we = we; v.dreg = dreg; v.lat = lat; v.mds = mds; v.mdd = mdd;
    v.mdu = mdu; v.fl = fl; v.es = es; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv;
    src_reg     = {v.s1, v.s0};
    src_used    = v.used;
    src_early   = v.early;
    dst_we      = v.we;
    dst_reg     = v.dreg;
    dst_lat     = v.lat;
    md_start    = v.mds;
    md_is_div   = v.mdd;
    md_use      = v.mdu;
    flush       = v.fl;
  endtask

  task automatic apply(input string nm, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk({nm, ".stall"}, stall, v.es);
    chk({nm, ".cause"}, stall_cause, v.ec);
  endtask

  task automatic model_reset();
    now = 0;
    md_rdy = 0;
    m_cnt = 0;
    for (int r = 0; r < NREG; r++) begin
      rdy_ex[r] = 0;
      rdy_id[r] = 0;
    end
  endtask

  task automatic model_eval(input vec_t v, output logic es, output logic [1:0] ec);
    logic raw, md;
    logic [4:0] rg;
    raw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rg = (i == 0) ? v.s0 : v.s1;
      if (v.used[i] && rg != 0)
        if (v.early[i] ? (now < rdy_id[rg]) : (now < rdy_ex[rg])) raw = 1'b1;
    end
    md = v.mdu && (now < md_rdy);
    es = v.iv && !v.fl && (raw || md);
    ec = !es ? 2'b00 : (raw ? 2'b01 : 2'b10);
  endtask

  task automatic model_step(input vec_t v, input logic es);
    logic acc;
    acc = v.iv && !es && !v.fl;
    if (v.fl) begin
      for (int r = 0; r < NREG; r++) begin
        rdy_ex[r] = 0;
        rdy_id[r] = 0;
      end
    end else if (acc && v.we && v.dreg != 0) begin
      rdy_ex[v.dreg] = now + v.lat;
      rdy_id[v.dreg] = now + v.lat + 1;
    end
    if (acc && v.mds) md_rdy = now + (v.mdd ? DLAT : MLAT) + 1;
    if (es && m_cnt < 65535) m_cnt++;
    now++;
  endtask

  task automatic model_cycle(input string nm, input vec_t v, input bit do_chk);
    logic es;
    logic [1:0] ec;
    model_eval(v, es, ec);
    @(negedge clk);
    drive(v);
    #1;
    if (do_chk) begin
      chk({nm, ".stall"}, stall, es);
      chk({nm, ".cause"}, stall_cause, ec);
      chk({nm, ".count"}, stall_count, m_cnt);
    end
    model_step(v, es);
  endtask

  vec_t tbl[$];
  vec_t idle;
  vec_t v;
  int   exp_cnt;

  initial begin
    idle = mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    drive(idle);
    rst_n = 1'b0;
    // Reset state, with an instruction that would hazard if state were nonzero.
    repeat (2) @(negedge clk);
    drive(mk(1, 8, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00));
    #1;
    chk("reset.stall", stall, 0);
    chk("reset.cause", stall_cause, 0);
    chk("reset.count", stall_count, 0);
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;

    // Directed cycle table, one row per clock.
    tbl.push_back(mk(1, 0, 0, 2'b00, 2'b00, 1, 8, 2, 0, 0, 0, 0, 0, 2'b00));   // load r8
    tbl.push_back(mk(1, 8, 1, 2'b11, 2'b00, 1, 9, 1, 0, 0, 0, 0, 1, 2'b01));   // addu r9,r8,r1
    tbl.push_back(mk(1, 8, 1, 2'b11, 2'b00, 1, 9, 1, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(mk(1, 9, 0, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01));   // beq r9,r0
    tbl.push_back(mk(1, 9, 0, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(mk(1, 0, 0, 2'b00, 2'b00, 1, 10, 2, 0, 0, 0, 0, 0, 2'b00));  // load r10
    tbl.push_back(mk(1, 10, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01));  // beq r10
    tbl.push_back(mk(1, 10, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01));
    tbl.push_back(mk(1, 10, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(mk(1, 0, 0, 2'b00, 2'b00, 1, 0, 2, 0, 0, 0, 0, 0, 2'b00));   // write r0 lat 2
    tbl.push_back(mk(1, 0, 0, 2'b11, 2'b01, 1, 11, 2, 0, 0, 0, 0, 0, 2'b00));  // read r0, load r11
    tbl.push_back(mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0, 0, 2'b00));   // div
    tbl.push_back(mk(1, 11, 0, 2'b01, 2'b01, 1, 12, 1, 0, 0, 1, 0, 1, 2'b01)); // mflo + RAW r11
    for (int k = 0; k < 9; k++)
      tbl.push_back(mk(1, 11, 0, 2'b01, 2'b01, 1, 12, 1, 0, 0, 1, 0, 1, 2'b10));
    tbl.push_back(mk(1, 11, 0, 2'b01, 2'b01, 1, 12, 1, 0, 0, 1, 0, 0, 2'b00));

    exp_cnt = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("tbl%0d", i), tbl[i]);
      chk($sformatf("tbl%0d.count", i), stall_count, exp_cnt);
      if (tbl[i].es) exp_cnt++;
    end
    @(negedge clk);
    drive(idle);
    #1;
    chk("tbl.final_count", stall_count, 14);

    // Flush clears the scoreboard but the mult keeps HI/LO busy.
    apply("fl.mult_load", mk(1, 0, 0, 2'b00, 2'b00, 1, 8, 2, 1, 0, 1, 0, 0, 2'b00));
    apply("fl.flush",     mk(1, 8, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00));
    apply("fl.use_r8",    mk(1, 8, 0, 2'b01, 2'b00, 1, 13, 7, 0, 0, 0, 0, 0, 2'b00));
    apply("fl.mflo",      mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 2'b10));

    // Asynchronous reset in the middle of both countdowns, between clock edges.
    apply("rst.pre", mk(1, 13, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 2'b01));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst.async_stall", stall, 0);
    chk("rst.async_cause", stall_cause, 0);
    chk("rst.async_count", stall_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("rst.post", mk(1, 13, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00));
    chk("rst.post_count", stall_count, 0);

    // Randomized traffic against the model.
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      v.iv    = ($urandom % 8) != 0;
      v.s0    = 5'($urandom % 6);
      v.s1    = 5'($urandom % 6);
      v.used  = 2'($urandom);
      v.early = 2'($urandom);
      v.we    = 1'($urandom);
      v.dreg  = 5'($urandom % 6);
      v.lat   = 3'($urandom);
      v.mds   = ($urandom % 6) == 0;
      v.mdd   = 1'($urandom);
      v.mdu   = v.mds || (($urandom % 4) == 0);
      v.fl    = ($urandom % 20) == 0;
      v.es    = 1'b0;
      v.ec    = 2'b00;
      model_cycle("rnd", v, 1'b1);
    end

    // Back-to-back divs stall 10 of every 11 cycles; run past 16'hFFFF.
    v = mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0, 0, 2'b00);
    for (int n = 0; n < 72100; n++) model_cycle("sat", v, 1'b0);
    model_cycle("sat_end", v, 1'b1);
    chk("sat.ffff", stall_count, 16'hFFFF);
    repeat (3) model_cycle("sat_hold", v, 1'b0);
    model_cycle("sat_hold", v, 1'b1);

    #1;
    rst_n = 1'b0;
    #1;
    chk("sat.async_count", stall_count, 0);
    chk("sat.async_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
